// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: DivOp encodings, divider state codes and default width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3[1:0] of the RV32M divide-class instructions
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_CALC = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on magnitudes; purely combinational.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   remIn,
  input  logic [XLEN-1:0] shiftIn,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   remOut,
  output logic [XLEN-1:0] shiftOut,
  output logic            qBit
);

  logic [XLEN+1:0] trial;

  // One guard bit above the widened remainder makes the borrow the quotient decision.
  assign trial    = {remIn, shiftIn[XLEN-1]} - {2'b00, divisor};
  assign qBit     = ~trial[XLEN+1];
  assign remOut   = qBit ? trial[XLEN:0] : {remIn[XLEN-1:0], shiftIn[XLEN-1]};
  assign shiftOut = {shiftIn[XLEN-2:0], 1'b0};

endmodule

// File: rtl/iterative_div_unit.sv
// Multi-cycle RV32M divider for the Execute stage; stalls the pipeline while iterating.
module iterative_div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StartE,
  input  logic            FlushE,
  input  logic [1:0]      DivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            StallReqE,
  output logic            DivDoneE,
  output logic [XLEN-1:0] DivResultE
);

  logic [1:0]       stateReg, stateNext;
  logic [XLEN:0]    remReg;
  logic [XLEN-1:0]  shiftReg, divisorReg, resultReg;
  logic [CNT_W-1:0] cntReg;
  logic             remSelReg, quotNegReg, remNegReg;

  logic             isSigned, signA, signB, divByZero, overflow, special;
  logic             accept, lastStep, stepQBit;
  logic [XLEN-1:0]  absA, absB, stepShift, quotNow, quotFinal, remFinal;
  logic [XLEN:0]    stepRem;

  assign isSigned  = ~DivOpE[0];
  assign signA     = isSigned & SrcAE[XLEN-1];
  assign signB     = isSigned & SrcBE[XLEN-1];
  assign absA      = signA ? (XLEN'(0) - SrcAE) : SrcAE;
  assign absB      = signB ? (XLEN'(0) - SrcBE) : SrcBE;
  assign divByZero = (SrcBE == '0);
  assign overflow  = isSigned & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
  assign special   = divByZero | overflow;
  assign accept    = (stateReg == DIV_IDLE) & StartE & ~FlushE;
  assign lastStep  = (cntReg == CNT_W'(XLEN-1));

  div_step #(.XLEN(XLEN)) uStep (
    .remIn   (remReg),
    .shiftIn (shiftReg),
    .divisor (divisorReg),
    .remOut  (stepRem),
    .shiftOut(stepShift),
    .qBit    (stepQBit)
  );

  // The step leaves the vacated LSB clear; the new quotient bit is merged here.
  assign quotNow   = stepShift | {{(XLEN-1){1'b0}}, stepQBit};
  assign quotFinal = quotNegReg ? (XLEN'(0) - quotNow) : quotNow;
  assign remFinal  = remNegReg ? (XLEN'(0) - stepRem[XLEN-1:0]) : stepRem[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= DIV_IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      DIV_IDLE: if (accept) stateNext = special ? DIV_DONE : DIV_CALC;
      DIV_CALC: begin
        if (FlushE)        stateNext = DIV_IDLE;
        else if (lastStep) stateNext = DIV_DONE;
      end
      default:  stateNext = DIV_IDLE;
    endcase
  end

  always_comb begin
    StallReqE = 1'b0;
    DivDoneE  = 1'b0;
    if (rst_n) begin
      case (stateReg)
        DIV_IDLE: StallReqE = StartE & ~FlushE;
        DIV_CALC: StallReqE = 1'b1;
        DIV_DONE: DivDoneE  = ~FlushE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remReg     <= '0;
      shiftReg   <= '0;
      divisorReg <= '0;
      resultReg  <= '0;
      cntReg     <= '0;
      remSelReg  <= 1'b0;
      quotNegReg <= 1'b0;
      remNegReg  <= 1'b0;
    end else if (accept) begin
      remSelReg  <= DivOpE[1];
      quotNegReg <= signA ^ signB;
      remNegReg  <= signA;
      remReg     <= '0;
      shiftReg   <= absA;
      divisorReg <= absB;
      cntReg     <= '0;
      if (divByZero)     resultReg <= DivOpE[1] ? SrcAE : '1;
      else if (overflow) resultReg <= DivOpE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else if (stateReg == DIV_CALC) begin
      remReg   <= stepRem;
      shiftReg <= quotNow;
      cntReg   <= cntReg + CNT_W'(1);
      // A flushed operation must not disturb the previously presented result.
      if (lastStep && !FlushE) resultReg <= remSelReg ? remFinal : quotFinal;
    end
  end

  assign DivResultE = resultReg;

endmodule

// File: tb/tb_iterative_div_unit.sv
// Self-checking bench for iterative_div_unit: directed RV32M cases plus random operations.
module tb_iterative_div_unit;
  import riscv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            StartE = 1'b0;
  logic            FlushE = 1'b0;
  logic [1:0]      DivOpE = 2'b00;
  logic [XLEN-1:0] SrcAE = '0;
  logic [XLEN-1:0] SrcBE = '0;
  logic            StallReqE;
  logic            DivDoneE;
  logic [XLEN-1:0] DivResultE;

  int              checksTotal = 0;
  int              checksPassed = 0;
  logic [XLEN-1:0] lastResult = '0;

  always #5 clk = ~clk;

  iterative_div_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StartE    (StartE),
    .FlushE    (FlushE),
    .DivOpE    (DivOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .StallReqE (StallReqE),
    .DivDoneE  (DivDoneE),
    .DivResultE(DivResultE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // RV32M semantics in plain 64-bit arithmetic (truncating division, remainder follows dividend).
  function automatic logic [31:0] refDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      DIV_OP_DIV:  return 32'(sa / sb);
      DIV_OP_DIVU: return 32'(ua / ub);
      DIV_OP_REM:  return 32'(sa % sb);
      default:     return 32'(ua % ub);
    endcase
  endfunction

  function automatic bit refSpecial(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Drives one instruction (StartE held until Done) and leaves StartE high afterwards.
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, stalls, dones, expLat;
    logic [31:0] res, expRes;
    expRes = refDiv(op, a, b);
    expLat = refSpecial(op, a, b) ? 1 : XLEN + 1;
    @(posedge clk); #1;
    StartE = 1'b1; DivOpE = op; SrcAE = a; SrcBE = b;
    lat = -1; stalls = 0; dones = 0; res = '0;
    for (int c = 0; c < XLEN + 10 && lat < 0; c++) begin
      @(negedge clk);
      if (StallReqE) stalls++;
      if (DivDoneE) begin
        dones++;
        lat = c;
        res = DivResultE;
      end
    end
    $display("%s op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d stalls=%0d",
             tag, op, a, b, res, lat, stalls);
    check({tag, "_result"}, res, expRes);
    check({tag, "_latency"}, 32'(lat), 32'(expLat));
    check({tag, "_stalls"}, 32'(stalls), 32'(expLat));
    check({tag, "_dones"}, 32'(dones), 32'd1);
    lastResult = expRes;
  endtask

  // Drops StartE and watches for spurious activity; the last result must hold.
  task automatic idle(input int n, input string tag);
    int spurious;
    spurious = 0;
    @(posedge clk); #1;
    StartE = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (DivDoneE || StallReqE) spurious++;
    end
    check({tag, "_quiet"}, 32'(spurious), 32'd0);
    check({tag, "_hold"}, DivResultE, lastResult);
  endtask

  initial begin
    logic [1:0]  dOp[8];
    logic [31:0] dA[8];
    logic [31:0] dB[8];
    logic [1:0]  op;
    logic [31:0] a, b;
    int          flushDones;

    dOp = '{DIV_OP_DIVU, DIV_OP_REMU, DIV_OP_DIV, DIV_OP_REM,
            DIV_OP_DIVU, DIV_OP_REMU, DIV_OP_DIV, DIV_OP_REM};
    dA  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    dB  = '{32'd7, 32'd7, 32'd2, 32'd2,
            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    // Reset holds outputs low even with a request present.
    StartE = 1'b1; SrcAE = 32'd5; SrcBE = 32'd1;
    #12;
    check("reset_stall", {31'b0, StallReqE}, 32'd0);
    check("reset_done", {31'b0, DivDoneE}, 32'd0);
    check("reset_result", DivResultE, 32'd0);
    StartE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      runOp(dOp[i], dA[i], dB[i], $sformatf("directed%0d", i));
      idle(2, $sformatf("directed%0d_idle", i));
    end

    // Flush in the tenth CALC cycle kills the divide without a Done pulse.
    @(posedge clk); #1;
    StartE = 1'b1; DivOpE = DIV_OP_DIVU; SrcAE = 32'd1000; SrcBE = 32'd3;
    repeat (10) @(posedge clk);
    #1 FlushE = 1'b1;
    @(negedge clk);
    check("flush_cycle_done", {31'b0, DivDoneE}, 32'd0);
    @(posedge clk); #1;
    FlushE = 1'b0; StartE = 1'b0;
    @(negedge clk);
    $display("flush DIVU 1000/3 at CALC cycle 10 stall=%0d done=%0d", StallReqE, DivDoneE);
    check("flush_next_stall", {31'b0, StallReqE}, 32'd0);
    flushDones = 0;
    for (int c = 0; c < XLEN + 5; c++) begin
      @(negedge clk);
      if (DivDoneE) flushDones++;
    end
    check("flush_no_done", 32'(flushDones), 32'd0);
    check("flush_hold", DivResultE, lastResult);
    runOp(DIV_OP_DIVU, 32'd9, 32'd3, "after_flush");
    idle(2, "after_flush_idle");

    // Back-to-back: StartE never drops; the second op is accepted the cycle after DONE.
    runOp(DIV_OP_DIV, 32'hFFFF_FFF7, 32'd4, "b2b_first");
    runOp(DIV_OP_DIV, 32'd100, 32'hFFFF_FFF9, "b2b_second");
    idle(3, "b2b_idle");

    // Reset mid-CALC abandons the operation.
    @(posedge clk); #1;
    StartE = 1'b1; DivOpE = DIV_OP_DIVU; SrcAE = 32'd12345; SrcBE = 32'd7;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("reset mid-CALC stall=%0d done=%0d result=0x%08h", StallReqE, DivDoneE, DivResultE);
    check("midreset_stall", {31'b0, StallReqE}, 32'd0);
    check("midreset_done", {31'b0, DivDoneE}, 32'd0);
    check("midreset_result", DivResultE, 32'd0);
    @(negedge clk);
    StartE = 1'b0;
    rst_n = 1'b1;
    lastResult = '0;
    idle(XLEN + 5, "post_reset");

    // Random operations, randomly back-to-back or separated by idle cycles.
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 1000);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      runOp(op, a, b, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), $sformatf("rand%0d_idle", i));
    end
    idle(2, "final_idle");

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
